xor_stream_checksum: RTL and testbench

XOR_STREAM_CHECKSUM -- requirements
Module: xor_stream_checksum

---
 rtl/xor_stream_checksum.sv | 120 ++++++++++++
 tb/tb_xor_stream_checksum.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_checksum.sv
// xor_stream_checksum
//
// Folds a stream of WIDTH-bit words into a per-frame checksum. The checksum is
// the bitwise XOR of every word in the frame, plus its parity and a word count
// that saturates at all-ones. A frame ends with the accepted word that has
// in_last set. The result is held until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_data/in_last are valid
//   in_ready   block accepts a word this cycle (registered state only)
//   in_data    input word
//   in_last    accepted word is the final word of its frame
//   out_valid  result presented (registered state only)
//   out_ready  consumer takes the result
//   out_xor    XOR of all words in the frame
//   out_parity reduction XOR of out_xor, inverted when ODD_PARITY != 0
//   out_count  words in the frame, saturating at all-ones

module xor_stream_checksum #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ODD_PARITY = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_xor,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    localparam logic             ParInv = (ODD_PARITY != 0);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             live_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] xor_q, xor_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             parity_q, parity_d;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] acc_next;

    // live_q keeps in_ready low while rst is high and until the first edge after it.
    assign in_ready  = live_q && (state_q == StAccum);
    assign out_valid = (state_q == StHold);
    assign out_xor    = xor_q;
    assign out_parity = parity_q;
    assign out_count  = count_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        xor_d    = xor_q;
        count_d  = count_q;
        parity_d = parity_q;

        accept   = in_valid && in_ready;
        acc_next = acc_q ^ in_data;
        cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

        case (state_q)
            StAccum: begin
                if (accept) begin
                    if (in_last) begin
                        xor_d    = acc_next;
                        count_d  = cnt_inc;
                        parity_d = (^acc_next) ^ ParInv;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StHold;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_inc;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StAccum;
            live_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            xor_q    <= '0;
            count_q  <= '0;
            parity_q <= ParInv;
        end else begin
            state_q  <= state_d;
            live_q   <= 1'b1;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            xor_q    <= xor_d;
            count_q  <= count_d;
            parity_q <= parity_d;
        end
    end

endmodule

// File: tb/tb_xor_stream_checksum.sv
// Bench for xor_stream_checksum: three instances share one stimulus stream
// (even parity / 16-bit count, odd parity, 2-bit saturating count). Expected
// results come from XOR-folding the frame's word list in the bench.

module tb_xor_stream_checksum;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, out_parity_a;
    logic [7:0]  out_xor_a;
    logic [15:0] out_count_a;
    logic        in_ready_b, out_valid_b, out_parity_b;
    logic [7:0]  out_xor_b;
    logic [15:0] out_count_b;
    logic        in_ready_c, out_valid_c, out_parity_c;
    logic [7:0]  out_xor_c;
    logic [1:0]  out_count_c;

    int total = 0;
    int bad   = 0;
    logic [7:0] words[$];

    always #5 clk = ~clk;

    xor_stream_checksum #(.WIDTH(8), .ODD_PARITY(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_xor(out_xor_a), .out_parity(out_parity_a),
        .out_count(out_count_a)
    );

    xor_stream_checksum #(.WIDTH(8), .ODD_PARITY(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_xor(out_xor_b), .out_parity(out_parity_b),
        .out_count(out_count_b)
    );

    xor_stream_checksum #(.WIDTH(8), .ODD_PARITY(0), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_xor(out_xor_c), .out_parity(out_parity_c),
        .out_count(out_count_c)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid_a"}, out_valid_a, 1'b0);
        check({tag, "_valid_b"}, out_valid_b, 1'b0);
        check({tag, "_valid_c"}, out_valid_c, 1'b0);
        check({tag, "_ready_a"}, in_ready_a, 1'b0);
        check({tag, "_ready_c"}, in_ready_c, 1'b0);
        check({tag, "_xor_a"}, out_xor_a, 8'h00);
        check({tag, "_xor_b"}, out_xor_b, 8'h00);
        check({tag, "_count_a"}, out_count_a, 16'd0);
        check({tag, "_count_c"}, out_count_c, 2'd0);
        check({tag, "_par_a"}, out_parity_a, 1'b0);
        check({tag, "_par_b"}, out_parity_b, 1'b1);
        check({tag, "_par_c"}, out_parity_c, 1'b0);
    endtask

    // Result expected in HOLD for a frame whose XOR is x and length is n.
    task automatic check_result(input string tag, input logic [7:0] x, input int n);
        int sat_c;
        sat_c = (n > 3) ? 3 : n;
        check({tag, "_valid_a"}, out_valid_a, 1'b1);
        check({tag, "_valid_b"}, out_valid_b, 1'b1);
        check({tag, "_valid_c"}, out_valid_c, 1'b1);
        check({tag, "_ready_a"}, in_ready_a, 1'b0);
        check({tag, "_xor_a"}, out_xor_a, x);
        check({tag, "_xor_b"}, out_xor_b, x);
        check({tag, "_xor_c"}, out_xor_c, x);
        check({tag, "_par_a"}, out_parity_a, ^x);
        check({tag, "_par_b"}, out_parity_b, ~^x);
        check({tag, "_par_c"}, out_parity_c, ^x);
        check({tag, "_count_a"}, out_count_a, n);
        check({tag, "_count_b"}, out_count_b, n);
        check({tag, "_count_c"}, out_count_c, sat_c);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted d.
    task automatic push(input logic [7:0] d, input logic l, input int gap);
        int guard;
        for (int i = 0; i < gap; i++) begin
            in_valid  = 1'b0;
            in_data   = 8'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        out_ready = 1'($urandom);
        guard = 0;
        @(negedge clk);
        while (in_ready_a !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("ready_timeout", in_ready_a, 1'b1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
    endtask

    // Sends words[], checks the result, holds it for bp cycles, then releases it.
    task automatic run_frame(input string tag, input int gap_max, input int bp);
        logic [7:0] x;
        int n;
        x = 8'h00;
        n = words.size();
        foreach (words[i]) x ^= words[i];
        foreach (words[i]) push(words[i], (i == n - 1), $urandom_range(gap_max, 0));
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(negedge clk);
        check_result(tag, x, n);
        for (int c = 0; c < bp; c++) begin
            @(posedge clk); #1;
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            @(negedge clk);
            check_result({tag, "_hold"}, x, n);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        @(negedge clk);
        check({tag, "_rel_valid"}, out_valid_a, 1'b0);
        check({tag, "_rel_ready"}, in_ready_a, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        // Power-up reset, checked while asserted and before any clock edge.
        #1 rst = 1'b1;
        #2 check_reset("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("rst_held");
        rst = 1'b0;
        #1 check("ready_before_edge", in_ready_a, 1'b0);
        @(posedge clk); #1;
        check("ready_after_edge", in_ready_a, 1'b1);

        // Three-word frame; expected XOR 0x96, count 3.
        words = '{8'h3C, 8'hA5, 8'h0F};
        run_frame("three_word", 0, 0);

        // Single-word frame.
        words = '{8'h01};
        run_frame("single", 0, 0);

        // Backpressure for five cycles with in_valid held high.
        words = '{8'($urandom), 8'($urandom), 8'($urandom)};
        run_frame("backpressure", 0, 5);

        // Count saturates in the CNT_W=2 instance.
        words = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_frame("saturate", 1, 1);

        // Reset after two of four words; the partial frame must vanish.
        push(8'h5A, 1'b0, 0);
        push(8'hC3, 1'b0, 0);
        #2 rst = 1'b1;
        #1 check_reset("rst_midframe");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        words = '{8'hFF, 8'hFF};
        run_frame("post_reset", 0, 0);

        // Reset while a result is pending; no stale out_valid afterwards.
        words = '{8'($urandom), 8'($urandom)};
        foreach (words[i]) push(words[i], (i == 1), 0);
        #2 rst = 1'b1;
        #1 check_reset("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("no_stale_valid", out_valid_a, 1'b0);
        check("ready_after_rst_hold", in_ready_a, 1'b1);
        @(posedge clk); #1;
        check("no_stale_valid_2", out_valid_a, 1'b0);

        // Random frames with random gaps and backpressure.
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(20, 1);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back(8'($urandom));
            run_frame("random", 2, $urandom_range(3, 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
